cpu_bus_port: RTL and testbench

CPU_BUS_PORT -- requirements
Module: cpu_bus_port

---
 rtl/cpu_bus_port_pkg.sv | 21 ++
 rtl/cpu_bus_port_tmo.sv | 31 +++
 rtl/cpu_bus_port.sv | 184 ++++++++++++++++++
 tb/tb_cpu_bus_port.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_port_pkg.sv
// Shared definitions for the CPU bus port: FSM state encoding, read/write
// constants and active-low bus signal levels.
package cpu_bus_port_pkg;

  // Bus-port FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } bus_state_t;

  // Access direction as carried on req_rw / bus_rw / spm_rw
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Levels of the active-low strobes, request and handshake lines
  localparam logic SIG_ASSERT = 1'b0;
  localparam logic SIG_NEGATE = 1'b1;

endpackage

// File: rtl/cpu_bus_port_tmo.sv
// Bus-wait timeout counter for the CPU bus port.
// Present only when CPU_BUS_TIMEOUT_EN is defined; otherwise this file is empty.
`ifdef CPU_BUS_TIMEOUT_EN
module cpu_bus_tmo #(
  parameter int TMO_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TMO_CYC);

  logic [CNT_W-1:0] count;

  // Count enabled wait cycles from zero, saturating at the limit
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule
`endif

// File: rtl/cpu_bus_port.sv
// CPU pipeline-stage memory port: scratch-pad hits are served combinationally,
// everything else goes through a request/grant/ready bus handshake.
// Optional feature: define CPU_BUS_TIMEOUT_EN to abort bus waits after TMO_CYC
// cycles with a one-cycle err pulse; without it err is tied low.
module cpu_bus_port #(
  parameter int                ADDR_W  = 30,
  parameter int                DATA_W  = 32,
  parameter int                TAG_W   = 3,
  parameter logic [TAG_W-1:0]  SPM_TAG = 3'b001,
  parameter int                TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_as_,
  input  logic              req_rw,
  input  logic [DATA_W-1:0] req_wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              err,
  input  logic [DATA_W-1:0] spm_rd_data,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_,
  input  logic              bus_grnt_,
  output logic              bus_req_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data
);

  import cpu_bus_port_pkg::*;

  bus_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] rd_buf;
  logic              discard_q;

  logic new_req;
  logic spm_hit;
  logic timeout;
  logic done;
  logic drop;

  assign new_req = !reset && (req_as_ == SIG_ASSERT) && !flush;
  assign spm_hit = (req_addr[ADDR_W-1 -: TAG_W] == SPM_TAG);

`ifdef CPU_BUS_TIMEOUT_EN
  logic expired;

  cpu_bus_tmo #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != ACCESS),
    .enable  (bus_rdy_ == SIG_NEGATE),
    .expired (expired)
  );

  assign timeout = (state == ACCESS) && (bus_rdy_ == SIG_NEGATE) && expired;
`else
  logic unused_tmo;

  assign unused_tmo = (TMO_CYC == 0);
  assign timeout    = 1'b0;
`endif

  assign done = (state == ACCESS) && ((bus_rdy_ == SIG_ASSERT) || timeout);
  assign drop = discard_q || flush;

  // Scratch-pad side simply follows the stage request
  assign spm_addr    = req_addr;
  assign spm_rw      = req_rw;
  assign spm_wr_data = req_wr_data;

  // Bus address/data carry the latched request only while a transfer is live
  assign bus_addr    = (state != IDLE) ? addr_q    : '0;
  assign bus_rw      = (state != IDLE) ? rw_q      : RW_WRITE;
  assign bus_wr_data = (state != IDLE) ? wr_data_q : '0;

  // FSM state, latched request, read buffer and flush-discard flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      rw_q      <= RW_WRITE;
      wr_data_q <= '0;
      rd_buf    <= '0;
      discard_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (new_req && !spm_hit) begin
            addr_q    <= req_addr;
            rw_q      <= req_rw;
            wr_data_q <= req_wr_data;
            discard_q <= 1'b0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (flush) begin
            state <= IDLE;
          end else if (bus_grnt_ == SIG_ASSERT) begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (flush) begin
            discard_q <= 1'b1;
          end
          if (done) begin
            rd_buf    <= timeout ? '0 : bus_rd_data;
            discard_q <= 1'b0;
            state     <= (!drop && stall) ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (!stall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake strobes, busy/err and read data decoded from state and inputs
  always_comb begin
    bus_req_ = SIG_NEGATE;
    bus_as_  = SIG_NEGATE;
    spm_as_  = SIG_NEGATE;
    busy     = 1'b0;
    err      = 1'b0;
    rd_data  = '0;
    case (state)
      IDLE: begin
        if (new_req) begin
          if (spm_hit) begin
            spm_as_ = SIG_ASSERT;
            if (req_rw == RW_READ) begin
              rd_data = spm_rd_data;
            end
          end else begin
            bus_req_ = SIG_ASSERT;
            busy     = 1'b1;
          end
        end
      end
      REQ: begin
        bus_req_ = SIG_ASSERT;
        busy     = 1'b1;
        if (!flush && (bus_grnt_ == SIG_ASSERT)) begin
          bus_as_ = SIG_ASSERT;
        end
      end
      ACCESS: begin
        bus_req_ = SIG_ASSERT;
        busy     = !done;
        err      = timeout;
        if (done && !drop && !timeout && (rw_q == RW_READ)) begin
          rd_data = bus_rd_data;
        end
      end
      HOLD: begin
        if (rw_q == RW_READ) begin
          rd_data = rd_buf;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_bus_port.sv
// Self-checking bench for cpu_bus_port: directed scenarios plus randomized
// transactions, with expected per-cycle outputs derived from transaction rules.
module tb_cpu_bus_port;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 3;
  localparam logic [TAG_W-1:0] SPM_TAG = 3'b001;
  localparam int TMO = 4;

  logic              clk;
  logic              reset;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] req_addr;
  logic              req_as_;
  logic              req_rw;
  logic [DATA_W-1:0] req_wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              err;
  logic [DATA_W-1:0] spm_rd_data;
  logic [ADDR_W-1:0] spm_addr;
  logic              spm_as_;
  logic              spm_rw;
  logic [DATA_W-1:0] spm_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;
  logic              bus_grnt_;
  logic              bus_req_;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_as_;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_wr_data;

  int checks;
  int errors;

  logic [ADDR_W-1:0] t_addr;
  logic              t_rw;
  logic [DATA_W-1:0] t_wd;

  cpu_bus_port #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TAG_W   (TAG_W),
    .SPM_TAG (SPM_TAG),
    .TMO_CYC (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .req_addr    (req_addr),
    .req_as_     (req_as_),
    .req_rw      (req_rw),
    .req_wr_data (req_wr_data),
    .rd_data     (rd_data),
    .busy        (busy),
    .err         (err),
    .spm_rd_data (spm_rd_data),
    .spm_addr    (spm_addr),
    .spm_as_     (spm_as_),
    .spm_rw      (spm_rw),
    .spm_wr_data (spm_wr_data),
    .bus_rd_data (bus_rd_data),
    .bus_rdy_    (bus_rdy_),
    .bus_grnt_   (bus_grnt_),
    .bus_req_    (bus_req_),
    .bus_addr    (bus_addr),
    .bus_as_     (bus_as_),
    .bus_rw      (bus_rw),
    .bus_wr_data (bus_wr_data)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic expectOutputs(input string tag, input logic e_req, input logic e_as, input logic e_spm,
                               input logic e_busy, input logic e_err, input logic [DATA_W-1:0] e_rd,
                               input logic latched);
    checkOutput({tag, ".bus_req_"}, 64'(bus_req_), 64'(e_req));
    checkOutput({tag, ".bus_as_"}, 64'(bus_as_), 64'(e_as));
    checkOutput({tag, ".spm_as_"}, 64'(spm_as_), 64'(e_spm));
    checkOutput({tag, ".busy"}, 64'(busy), 64'(e_busy));
    checkOutput({tag, ".err"}, 64'(err), 64'(e_err));
    checkOutput({tag, ".rd_data"}, 64'(rd_data), 64'(e_rd));
    checkOutput({tag, ".bus_addr"}, 64'(bus_addr), latched ? 64'(t_addr) : 64'd0);
    checkOutput({tag, ".bus_rw"}, 64'(bus_rw), latched ? 64'(t_rw) : 64'd0);
    checkOutput({tag, ".bus_wr_data"}, 64'(bus_wr_data), latched ? 64'(t_wd) : 64'd0);
  endtask

  function automatic logic [ADDR_W-1:0] missAddr();
    logic [TAG_W-1:0] tg;
    do tg = TAG_W'($urandom_range(0, 7)); while (tg == SPM_TAG);
    return {tg, (ADDR_W-TAG_W)'($urandom)};
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #5;
  endtask

  task automatic idleInputs();
    req_as_     = 1'b1;
    flush       = 1'b0;
    stall       = 1'b0;
    bus_grnt_   = 1'b1;
    bus_rdy_    = 1'b1;
    req_addr    = ADDR_W'($urandom);
    req_rw      = 1'($urandom);
    req_wr_data = $urandom;
    bus_rd_data = $urandom;
    spm_rd_data = $urandom;
  endtask

  // Inputs that must be ignored while a bus transfer is in flight
  task automatic noiseInputs();
    idleInputs();
    req_as_   = 1'($urandom);
    stall     = 1'($urandom);
    bus_grnt_ = 1'($urandom);
  endtask

  task automatic spmTxn(input logic [ADDR_W-1:0] addr, input logic rw, input logic [DATA_W-1:0] sdat, input logic fl);
    t_addr = addr;
    t_rw   = rw;
    t_wd   = $urandom;
    nextCycle();
    idleInputs();
    req_as_     = 1'b0;
    req_addr    = addr;
    req_rw      = rw;
    req_wr_data = t_wd;
    spm_rd_data = sdat;
    flush       = fl;
    stall       = 1'($urandom);
    settle();
    if (fl) expectOutputs("spm_flush", 1, 1, 1, 0, 0, '0, 0);
    else    expectOutputs("spm", 1, 1, 0, 0, 0, rw ? sdat : '0, 0);
    checkOutput("spm_addr", 64'(spm_addr), 64'(addr));
    checkOutput("spm_rw", 64'(spm_rw), 64'(rw));
    checkOutput("spm_wr_data", 64'(spm_wr_data), 64'(t_wd));
  endtask

  task automatic missFlushTxn();
    nextCycle();
    idleInputs();
    req_as_  = 1'b0;
    req_addr = missAddr();
    flush    = 1'b1;
    settle();
    expectOutputs("idle_flush", 1, 1, 1, 0, 0, '0, 0);
    nextCycle();
    idleInputs();
    settle();
    expectOutputs("idle_flush_after", 1, 1, 1, 0, 0, '0, 0);
  endtask

  // kind: 1 plain, 2 flush in REQ, 3 flush in ACCESS, 4 timeout, 5 reset in ACCESS
  // g: REQ cycles before grant, r: ACCESS cycles before ready,
  // s: HOLD cycles (last one releases stall), fk: ACCESS cycle carrying flush
  task automatic busTxn(input int kind, input logic [ADDR_W-1:0] addr, input logic rw,
                        input logic [DATA_W-1:0] rdat, input int g, input int r, input int s, input int fk);
    logic [DATA_W-1:0] exp_rd;
    t_addr = addr;
    t_rw   = rw;
    t_wd   = $urandom;
    nextCycle();
    idleInputs();
    req_as_     = 1'b0;
    req_addr    = addr;
    req_rw      = rw;
    req_wr_data = t_wd;
    settle();
    expectOutputs("bus_request", 0, 1, 1, 1, 0, '0, 0);
    for (int i = 0; i < g; i++) begin
      nextCycle();
      noiseInputs();
      bus_grnt_ = 1'b1;
      settle();
      expectOutputs("req_wait", 0, 1, 1, 1, 0, '0, 1);
    end
    nextCycle();
    noiseInputs();
    if (kind == 2) begin
      flush = 1'b1;
      settle();
      expectOutputs("req_flush", 0, 1, 1, 1, 0, '0, 1);
      nextCycle();
      idleInputs();
      settle();
      expectOutputs("req_flush_after", 1, 1, 1, 0, 0, '0, 0);
      return;
    end
    bus_grnt_ = 1'b0;
    settle();
    expectOutputs("grant", 0, 0, 1, 1, 0, '0, 1);
    if (kind == 4) begin
      for (int a = 0; a < TMO; a++) begin
        nextCycle();
        noiseInputs();
        settle();
        expectOutputs("tmo_wait", 0, 1, 1, 1, 0, '0, 1);
      end
      nextCycle();
      noiseInputs();
      stall = 1'b0;
      settle();
      expectOutputs("timeout", 0, 1, 1, 0, 1, '0, 1);
      nextCycle();
      idleInputs();
      settle();
      expectOutputs("timeout_after", 1, 1, 1, 0, 0, '0, 0);
      return;
    end
    for (int a = 0; a < r; a++) begin
      nextCycle();
      noiseInputs();
      if (kind == 3 && a == fk) flush = 1'b1;
      settle();
      expectOutputs("acc_wait", 0, 1, 1, 1, 0, '0, 1);
    end
    if (kind == 5) begin
      nextCycle();
      noiseInputs();
      reset = 1'b1;
      settle();
      expectOutputs("acc_reset", 0, 1, 1, 1, 0, '0, 1);
      nextCycle();
      reset = 1'b0;
      idleInputs();
      settle();
      expectOutputs("after_reset", 1, 1, 1, 0, 0, '0, 0);
      spmTxn({SPM_TAG, (ADDR_W-TAG_W)'($urandom)}, 1'b1, $urandom, 1'b0);
      return;
    end
    nextCycle();
    noiseInputs();
    bus_rdy_    = 1'b0;
    bus_rd_data = rdat;
    stall       = (kind == 3) ? 1'($urandom) : (s > 0);
    if (kind == 3 && fk >= r) flush = 1'b1;
    exp_rd = (kind == 1 && rw) ? rdat : '0;
    settle();
    expectOutputs("complete", 0, 1, 1, 0, 0, exp_rd, 1);
    if (kind == 1) begin
      for (int h = 1; h <= s; h++) begin
        nextCycle();
        noiseInputs();
        req_addr = ($urandom_range(0, 1) == 1) ? {SPM_TAG, (ADDR_W-TAG_W)'($urandom)} : missAddr();
        stall    = (h < s);
        settle();
        expectOutputs("hold", 1, 1, 1, 0, 0, exp_rd, 1);
      end
    end
    nextCycle();
    idleInputs();
    settle();
    expectOutputs("complete_after", 1, 1, 1, 0, 0, '0, 0);
  endtask

  task automatic applyStimulus(input int sel);
    int r;
    r = $urandom_range(0, 3);
    case (sel)
      0, 1, 2: spmTxn({SPM_TAG, (ADDR_W-TAG_W)'($urandom)}, 1'($urandom), $urandom, 1'b0);
      3:       missFlushTxn();
      4, 5, 6: busTxn(1, missAddr(), 1'($urandom), $urandom, $urandom_range(0, 3), r, $urandom_range(0, 4), 0);
      7:       busTxn(2, missAddr(), 1'($urandom), $urandom, $urandom_range(0, 3), r, 0, 0);
      8:       busTxn(3, missAddr(), 1'($urandom), $urandom, $urandom_range(0, 3), r, 0, $urandom_range(0, r));
`ifdef CPU_BUS_TIMEOUT_EN
      9:       busTxn(4, missAddr(), 1'($urandom), $urandom, $urandom_range(0, 3), 0, 0, 0);
`else
      9:       busTxn(1, missAddr(), 1'($urandom), $urandom, $urandom_range(0, 3), r, 0, 0);
`endif
      default: busTxn(5, missAddr(), 1'($urandom), $urandom, $urandom_range(0, 3), r, 0, 0);
    endcase
  endtask

  // Reset check, directed scenarios, then randomized transactions
  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idleInputs();
    repeat (3) @(posedge clk);
    #1;
    settle();
    expectOutputs("reset", 1, 1, 1, 0, 0, '0, 0);
    reset = 1'b0;

    spmTxn(30'h0800_0010, 1'b1, 32'h1234_5678, 1'b0);
    busTxn(1, 30'h1000_0000, 1'b1, 32'hDEAD_BEEF, 2, 2, 0, 0);
    busTxn(1, 30'h1000_0000, 1'b1, 32'hDEAD_BEEF, 2, 2, 5, 0);
    busTxn(1, 30'h1000_0004, 1'b0, 32'hCAFE_F00D, 0, 0, 2, 0);
    busTxn(2, 30'h1000_0008, 1'b1, 32'h0, 1, 0, 0, 0);
    busTxn(3, 30'h1000_000C, 1'b1, 32'h5555_AAAA, 0, 2, 0, 1);
    missFlushTxn();
    spmTxn(30'h0800_0020, 1'b1, 32'h0BAD_F00D, 1'b1);
`ifdef CPU_BUS_TIMEOUT_EN
    busTxn(4, 30'h1000_0010, 1'b1, 32'h0, 1, 0, 0, 0);
`endif
    busTxn(5, 30'h1000_0014, 1'b1, 32'h0, 1, 2, 0, 0);

    for (int n = 0; n < 200; n++) begin
      applyStimulus($urandom_range(0, 10));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
